// File: rtl/writeback_load_unit.sv
// Purpose: writeback consumer of load responses; tracks one outstanding load and merges ALU results via a one-entry hold buffer.
// Latency: register-file write one cycle after a matching load response or an accepted ALU result (issue N, valid N+1, write N+2 minimum).
// Backpressure: stall holds upstream while a load is in flight and unmatched; alu_ready drops while the hold buffer is occupied.
//
// Ports:
//   clock, reset         - rising-edge clock, asynchronous active-low reset
//   issue_*              - load accepted by the memory unit (address, funct3, destination)
//   alu_valid/rd/result  - non-load result offered for writeback; alu_ready accepts it
//   data_addr/load_data  - returned word and its word-aligned address, qualified by valid
//   report               - debug display enable (no effect on datapath)
//   write_*              - registered register-file write port
//   stall, load_pending  - pipeline hold and outstanding-load indication
//   error                - sticky alignment / illegal-funct3 / protocol error
module writeback_load_unit #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_load,
  input  logic [ADDRESS_BITS-1:0] issue_address,
  input  logic [2:0]              issue_funct3,
  input  logic [4:0]              issue_rd,
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rd,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic [ADDRESS_BITS-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic                    valid,
  input  logic                    report,
  output logic                    write_enable,
  output logic [4:0]              write_sel,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic                    stall,
  output logic                    alu_ready,
  output logic                    load_pending,
  output logic                    error
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Debug display hook has no hardware meaning; keep the port and index without logic.
  localparam int unused_core = CORE;
  logic unused_report;
  assign unused_report = report;

  logic [0:0]              state;
  logic [ADDRESS_BITS-1:0] cap_addr;
  logic [2:0]              cap_funct3;
  logic [4:0]              cap_rd;

  logic                    hold_vld;
  logic [4:0]              hold_rd;
  logic [DATA_WIDTH-1:0]   hold_dat;

  logic                    match;
  logic                    issue_legal;
  logic                    issue_aligned;
  logic                    issue_ok;
  logic                    alu_accept;
  logic [7:0]              lane_b;
  logic [15:0]             lane_h;
  logic                    sign_ext;
  logic [DATA_WIDTH-1:0]   load_val;

  assign load_pending = (state == WAIT);
  assign alu_ready    = ~hold_vld;
  assign alu_accept   = alu_valid & alu_ready;

  // Returned words are word aligned, so compare against the captured address with its byte offset cleared.
  assign match = load_pending & valid &
                 (data_addr == {cap_addr[ADDRESS_BITS-1:2], 2'b00});
  assign stall = load_pending & ~match;

  assign issue_legal = (issue_funct3 == 3'b000) || (issue_funct3 == 3'b001) ||
                       (issue_funct3 == 3'b010) || (issue_funct3 == 3'b100) ||
                       (issue_funct3 == 3'b101);
  // funct3[1:0]==01 covers LH and LHU; 010 is LW.
  assign issue_aligned = !((issue_funct3[1:0] == 2'b01) && issue_address[0]) &&
                         !((issue_funct3 == 3'b010) && (issue_address[1:0] != 2'b00));
  assign issue_ok = issue_legal & issue_aligned;

  // Lane extraction and extension from the captured request.
  always_comb begin
    lane_b = 8'h00;
    case (cap_addr[1:0])
      2'b00:   lane_b = load_data[7:0];
      2'b01:   lane_b = load_data[15:8];
      2'b10:   lane_b = load_data[23:16];
      default: lane_b = load_data[31:24];
    endcase
    lane_h   = cap_addr[1] ? load_data[31:16] : load_data[15:0];
    sign_ext = ~cap_funct3[2];
    load_val = load_data;
    case (cap_funct3[1:0])
      2'b00:   load_val = {{(DATA_WIDTH-8){sign_ext & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{(DATA_WIDTH-16){sign_ext & lane_h[15]}}, lane_h};
      default: load_val = load_data;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cap_addr     <= '0;
      cap_funct3   <= 3'b000;
      cap_rd       <= 5'd0;
      hold_vld     <= 1'b0;
      hold_rd      <= 5'd0;
      hold_dat     <= '0;
      write_enable <= 1'b0;
      write_sel    <= 5'd0;
      write_data   <= '0;
      error        <= 1'b0;
    end else begin
      // Writeback arbitration: load match, then held ALU entry, then direct ALU.
      write_enable <= 1'b0;
      if (match) begin
        write_enable <= (cap_rd != 5'd0);
        write_sel    <= cap_rd;
        write_data   <= load_val;
        if (alu_accept) begin
          hold_vld <= 1'b1;
          hold_rd  <= alu_rd;
          hold_dat <= alu_result;
        end
      end else if (hold_vld) begin
        // alu_ready is low here, so no newer result can overtake the held one.
        write_enable <= 1'b1;
        write_sel    <= hold_rd;
        write_data   <= hold_dat;
        hold_vld     <= 1'b0;
      end else if (alu_accept) begin
        write_enable <= 1'b1;
        write_sel    <= alu_rd;
        write_data   <= alu_result;
      end

      // Request tracking: a new issue is only acceptable when nothing is outstanding
      // or the outstanding load completes in this same cycle.
      if (issue_load && (state == IDLE || match)) begin
        if (issue_ok) begin
          state      <= WAIT;
          cap_addr   <= issue_address;
          cap_funct3 <= issue_funct3;
          cap_rd     <= issue_rd;
        end else begin
          state <= IDLE;
          error <= 1'b1;
        end
      end else if (issue_load) begin
        error <= 1'b1;
      end else if (match) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_writeback_load_unit.sv
// Purpose: directed self-checking bench for writeback_load_unit.
// Latency: checks registered outputs 1 time unit after each rising edge.
// Backpressure: exercises stall on unmatched responses and alu_ready with the hold buffer.
module tb_writeback_load_unit;

  logic        clock;
  logic        reset;
  logic        issue_load;
  logic [19:0] issue_address;
  logic [2:0]  issue_funct3;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic [19:0] data_addr;
  logic [31:0] load_data;
  logic        valid;
  logic        report;
  logic        write_enable;
  logic [4:0]  write_sel;
  logic [31:0] write_data;
  logic        stall;
  logic        alu_ready;
  logic        load_pending;
  logic        error;

  int errs;
  int checks;

  writeback_load_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clock), .reset(reset),
    .issue_load(issue_load), .issue_address(issue_address),
    .issue_funct3(issue_funct3), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .data_addr(data_addr), .load_data(load_data), .valid(valid),
    .report(report),
    .write_enable(write_enable), .write_sel(write_sel), .write_data(write_data),
    .stall(stall), .alu_ready(alu_ready), .load_pending(load_pending), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [19:0] a, input logic [2:0] f3, input logic [4:0] rd);
    issue_load    = 1'b1;
    issue_address = a;
    issue_funct3  = f3;
    issue_rd      = rd;
  endtask

  task automatic resp(input logic [19:0] a, input logic [31:0] d);
    valid     = 1'b1;
    data_addr = a;
    load_data = d;
  endtask

  task automatic idle_inputs();
    issue_load = 1'b0;
    valid      = 1'b0;
    alu_valid  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_we"},      {31'd0, write_enable}, 32'd0);
    chk({pfx, "_sel"},     {27'd0, write_sel},    32'd0);
    chk({pfx, "_data"},    write_data,            32'd0);
    chk({pfx, "_error"},   {31'd0, error},        32'd0);
    chk({pfx, "_stall"},   {31'd0, stall},        32'd0);
    chk({pfx, "_pending"}, {31'd0, load_pending}, 32'd0);
    chk({pfx, "_aluready"},{31'd0, alu_ready},    32'd1);
  endtask

  initial begin
    errs = 0;
    checks = 0;
    reset = 1'b0;
    report = 1'b0;
    issue_address = '0; issue_funct3 = 3'b000; issue_rd = 5'd0;
    alu_rd = 5'd0; alu_result = '0; data_addr = '0; load_data = '0;
    idle_inputs();

    // Reset state
    tick(); tick();
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // LB with sign extension from byte lane 3
    issue(20'h00103, 3'b000, 5'd5);
    tick();
    idle_inputs();
    chk("lb_pending", {31'd0, load_pending}, 32'd1);
    chk("lb_we_early", {31'd0, write_enable}, 32'd0);
    resp(20'h00100, 32'h80FF_1234);
    #1;
    chk("lb_stall_match", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    chk("lb_we", {31'd0, write_enable}, 32'd1);
    chk("lb_sel", {27'd0, write_sel}, 32'd5);
    chk("lb_data", write_data, 32'hFFFF_FF80);
    chk("lb_idle", {31'd0, load_pending}, 32'd0);
    tick();
    chk("lb_we_oneshot", {31'd0, write_enable}, 32'd0);

    // LHU with an ignored mismatched response first
    issue(20'h00202, 3'b101, 5'd6);
    tick();
    idle_inputs();
    resp(20'h00300, 32'h1111_2222);
    #1;
    chk("lhu_stall_wrong", {31'd0, stall}, 32'd1);
    tick();
    idle_inputs();
    chk("lhu_still_pending", {31'd0, load_pending}, 32'd1);
    chk("lhu_no_write", {31'd0, write_enable}, 32'd0);
    resp(20'h00200, 32'hBEEF_0001);
    tick();
    idle_inputs();
    chk("lhu_we", {31'd0, write_enable}, 32'd1);
    chk("lhu_sel", {27'd0, write_sel}, 32'd6);
    chk("lhu_data", write_data, 32'h0000_BEEF);

    // Misaligned LW raises sticky error, next aligned load works
    issue(20'h00006, 3'b010, 5'd3);
    tick();
    idle_inputs();
    chk("mis_error", {31'd0, error}, 32'd1);
    chk("mis_pending", {31'd0, load_pending}, 32'd0);
    chk("mis_we", {31'd0, write_enable}, 32'd0);
    issue(20'h00008, 3'b010, 5'd4);
    tick();
    idle_inputs();
    chk("lw_pending", {31'd0, load_pending}, 32'd1);
    resp(20'h00008, 32'h1234_5678);
    tick();
    idle_inputs();
    chk("lw_we", {31'd0, write_enable}, 32'd1);
    chk("lw_sel", {27'd0, write_sel}, 32'd4);
    chk("lw_data", write_data, 32'h1234_5678);
    chk("lw_error_sticky", {31'd0, error}, 32'd1);

    // Load match collides with an ALU result: load first, ALU held one cycle
    issue(20'h00012, 3'b001, 5'd9);
    tick();
    idle_inputs();
    resp(20'h00010, 32'h8001_7FFF);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h0000_0055;
    #1;
    chk("col_aluready_pre", {31'd0, alu_ready}, 32'd1);
    tick();
    idle_inputs();
    chk("col_load_we", {31'd0, write_enable}, 32'd1);
    chk("col_load_sel", {27'd0, write_sel}, 32'd9);
    chk("col_load_data", write_data, 32'hFFFF_8001);
    chk("col_aluready_busy", {31'd0, alu_ready}, 32'd0);
    tick();
    chk("col_alu_we", {31'd0, write_enable}, 32'd1);
    chk("col_alu_sel", {27'd0, write_sel}, 32'd7);
    chk("col_alu_data", write_data, 32'h0000_0055);
    chk("col_aluready_free", {31'd0, alu_ready}, 32'd1);

    // Direct ALU write with no load activity
    alu_valid = 1'b1; alu_rd = 5'd8; alu_result = 32'h0000_A5A5;
    tick();
    idle_inputs();
    chk("alu_we", {31'd0, write_enable}, 32'd1);
    chk("alu_sel", {27'd0, write_sel}, 32'd8);
    chk("alu_data", write_data, 32'h0000_A5A5);

    // Back-to-back: completion and new issue together; second load targets x0
    issue(20'h00021, 3'b100, 5'd10);
    tick();
    idle_inputs();
    resp(20'h00020, 32'h0000_C300);
    issue(20'h00024, 3'b010, 5'd0);
    tick();
    idle_inputs();
    chk("b2b_we", {31'd0, write_enable}, 32'd1);
    chk("b2b_sel", {27'd0, write_sel}, 32'd10);
    chk("b2b_data", write_data, 32'h0000_00C3);
    chk("b2b_pending", {31'd0, load_pending}, 32'd1);
    resp(20'h00024, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    chk("rd0_we", {31'd0, write_enable}, 32'd0);
    chk("rd0_pending", {31'd0, load_pending}, 32'd0);

    // Reset in WAIT abandons the load
    issue(20'h00030, 3'b010, 5'd11);
    tick();
    idle_inputs();
    chk("rstw_pending", {31'd0, load_pending}, 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("rstw");
    tick();
    reset = 1'b1;
    resp(20'h00030, 32'hCAFE_F00D);
    tick();
    idle_inputs();
    chk("rstw_no_write", {31'd0, write_enable}, 32'd0);

    // Issue while an unmatched load is outstanding: error, new request dropped
    issue(20'h00040, 3'b010, 5'd12);
    tick();
    issue(20'h00044, 3'b010, 5'd13);
    tick();
    idle_inputs();
    chk("prot_error", {31'd0, error}, 32'd1);
    chk("prot_pending", {31'd0, load_pending}, 32'd1);
    resp(20'h00040, 32'h0000_0001);
    tick();
    idle_inputs();
    chk("prot_we", {31'd0, write_enable}, 32'd1);
    chk("prot_sel", {27'd0, write_sel}, 32'd12);
    chk("prot_data", write_data, 32'h0000_0001);
    chk("prot_idle", {31'd0, load_pending}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/writeback_load_unit.md
# writeback_load_unit

Writeback-side consumer of the memory unit's load response path. It tracks one outstanding load request from the memory stage and matches the returned word against the request address. It extracts and sign- or zero-extends the addressed byte, halfword or word, then drives a registered register-file write. It merges this with non-load ALU results through a one-entry hold buffer, and stalls the pipeline while a load is in flight.

## Interface
Parameters:
- CORE, 0, core index for debug report
- DATA_WIDTH, 32, data word width (fixed at 32 for extension logic)
- ADDRESS_BITS, 20, byte-address width

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- issue_load  in  1  load accepted by memory unit this cycle (load & ready)
- issue_address  in  ADDRESS_BITS  byte address of the load
- issue_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- issue_rd  in  5  destination register of the load
- alu_valid  in  1  non-load result presented for writeback
- alu_rd  in  5  destination of ALU result
- alu_result  in  DATA_WIDTH  ALU result
- data_addr  in  ADDRESS_BITS  byte address (word aligned) of returned load word
- load_data  in  DATA_WIDTH  returned load word
- valid  in  1  load_data/data_addr valid
- report  in  1  enables per-cycle debug display
- write_enable  out  1  register-file write strobe
- write_sel  out  5  register-file write index
- write_data  out  DATA_WIDTH  register-file write data
- stall  out  1  hold upstream stages
- alu_ready  out  1  ALU hold buffer can accept
- load_pending  out  1  FSM in WAIT
- error  out  1  sticky protocol/alignment error

## Operation
- FSM states: IDLE, WAIT.
- IDLE + issue_load, aligned, legal funct3: capture address, funct3, rd; go to WAIT.
- Misaligned request: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0. Illegal funct3: 011, 110, 111. Either one sets error and stays IDLE; no write.
- WAIT: match = valid & (data_addr == {captured_addr[ADDRESS_BITS-1:2],2'b00}).
- On match: lane select by captured_addr[1:0] (byte) or captured_addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Register the write; return to IDLE.
- WAIT + valid without match: response ignored; no state change.
- WAIT + issue_load without match: protocol violation. Set error, request dropped.
- Match and issue_load in the same cycle: complete the current load and capture the new one; stay in WAIT.
- rd == 0: the load completes normally but write_enable stays 0.
- ALU path:
  - alu_valid & alu_ready with no match that cycle and hold empty: write directly.
  - Same cycle as a match: the load wins; the ALU result goes to the hold buffer.
  - Hold buffer full: it drains on the next cycle that has no match, and alu_ready = 0 until then.
  - The held entry is written before any newer ALU result.
- Priority per cycle: load match, then held ALU entry, then direct ALU.
- error clears only on reset.

## Timing
- Reset (low, async): state IDLE; write_enable 0, write_sel 0, write_data 0, error 0, hold buffer empty.
  - Outputs after reset: stall 0, load_pending 0, alu_ready 1.
  - Reset asserted mid-WAIT abandons the load; a later valid is ignored.
- write_enable/write_sel/write_data are registered. They assert exactly one cycle after the matching valid edge or accepted ALU cycle, for one cycle.
- Minimum load-to-write latency: issue cycle N, valid cycle N+1, write_enable cycle N+2.
- stall = load_pending & ~match (combinational).
- load_pending, alu_ready are registered state decodes.

## Test plan
- LB: issue_address 0x00103, funct3 000; valid data_addr 0x00100, load_data 0x80FF_1234 -> write_data 0xFFFF_FF80, write_enable one cycle later.
- LHU: addr 0x00202, funct3 101; wrong valid data_addr 0x00300 ignored with stall=1; then 0x00200, data 0xBEEF_0001 -> 0x0000_BEEF.
- Misaligned LW at 0x00006 -> error=1, load_pending=0, no write. Next load at 0x00008 works normally.
- Load match coincides with alu_valid (rd 7, 0x55) -> load written at cycle N+1, ALU written N+2, alu_ready=0 at N+1.
- Back-to-back: match and new issue_load in the same cycle -> load_pending stays 1, both writes occur; rd=0 load produces no write_enable.
- Reset asserted during WAIT -> all outputs zero, stall 0; a subsequent valid produces no write.
